// File: rtl/head_assembler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : head_assembler_pkg
//  Description : Shared parser defaults, FSM state encoding and tag layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package head_assembler_pkg;

    localparam int c_DEF_DATA_WIDTH = 256;
    localparam int c_DEF_HEAD_WIDTH = 1024;
    localparam int c_DEF_TAG_WIDTH  = 8;
    localparam int c_DEF_META_WIDTH = 512;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    typedef struct packed {
        logic                         valid;
        logic [c_DEF_TAG_WIDTH-2:0]   pkt_id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/head_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : head_assembler
//  Description : Gathers the first HEAD_WIDTH bits of each packet into a
//                tagged head vector for the first parser layer.
//  Revision    : 1.0 - initial release
// ============================================================================
module head_assembler
    import head_assembler_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int HEAD_WIDTH = c_DEF_HEAD_WIDTH,
    parameter int TAG_WIDTH  = c_DEF_TAG_WIDTH,
    parameter int META_WIDTH = c_DEF_META_WIDTH
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_enable,
    input  logic                             i_data_valid,
    input  logic                             i_data_sop,
    input  logic                             i_data_eop,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic                             o_data_ready,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0]  o_head,
    output logic [META_WIDTH+TAG_WIDTH-1:0]  o_meta,
    output logic [31:0]                      o_head_cnt,
    output logic [15:0]                      o_err_cnt
);

    localparam int c_HEAD_BEATS = HEAD_WIDTH / DATA_WIDTH;
    localparam int c_IDX_W      = (c_HEAD_BEATS > 1) ? $clog2(c_HEAD_BEATS) : 1;
    localparam int c_ID_W       = TAG_WIDTH - 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_HEAD_BEATS - 1);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [c_IDX_W-1:0]              r_beat_idx;
    logic [c_IDX_W-1:0]              w_slot;
    logic [HEAD_WIDTH-1:0]           r_head;
    logic [HEAD_WIDTH-1:0]           w_head_nxt;
    logic [c_ID_W-1:0]               r_pkt_id;
    logic [HEAD_WIDTH+TAG_WIDTH-1:0] r_head_out;
    logic [META_WIDTH+TAG_WIDTH-1:0] r_meta_out;
    logic [31:0]                     r_head_cnt;
    logic [15:0]                     r_err_cnt;
    logic                            w_ready;
    logic                            w_accept;
    logic                            w_capture;
    logic                            w_emit;
    logic                            w_err;

    // Ready only gates admission of new packets; an open packet always flows.
    assign w_ready  = ~i_rst & ((r_state != S_IDLE) | i_enable);
    assign w_accept = i_data_valid & w_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_emit      = 1'b0;
        w_err       = 1'b0;
        w_slot      = r_beat_idx;
        if (w_accept) begin
            if (i_data_sop) begin
                // A sop always starts a fresh head; one arriving mid-packet is an error.
                w_capture = 1'b1;
                w_slot    = '0;
                w_err     = (r_state != S_IDLE);
            end else begin
                case (r_state)
                    S_IDLE:    w_err = 1'b1;
                    S_COLLECT: w_capture = 1'b1;
                    S_DRAIN:   if (i_data_eop) w_state_nxt = S_IDLE;
                    default:   w_state_nxt = S_IDLE;
                endcase
            end
            if (w_capture) begin
                w_emit = i_data_eop | (w_slot == c_LAST_IDX);
                if (w_emit) begin
                    w_state_nxt = i_data_eop ? S_IDLE : S_DRAIN;
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end
        end
    end

    always_comb begin
        w_head_nxt = (w_accept & i_data_sop) ? '0 : r_head;
        for (int b = 0; b < c_HEAD_BEATS; b++) begin
            if (w_slot == c_IDX_W'(b)) begin
                w_head_nxt[HEAD_WIDTH-1-b*DATA_WIDTH -: DATA_WIDTH] = i_data;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_beat_idx <= '0;
            r_head     <= '0;
            r_pkt_id   <= '0;
            r_head_out <= '0;
            r_meta_out <= '0;
            r_head_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_capture && !w_emit) begin
                r_beat_idx <= w_slot + 1'b1;
            end else if (w_accept) begin
                r_beat_idx <= '0;
            end
            if (w_capture) begin
                r_head <= w_head_nxt;
            end
            r_head_out <= w_emit ? {w_head_nxt, 1'b1, r_pkt_id} : '0;
            r_meta_out <= w_emit ? {{META_WIDTH{1'b0}}, 1'b1, r_pkt_id} : '0;
            if (w_emit) begin
                r_pkt_id   <= r_pkt_id + 1'b1;
                r_head_cnt <= r_head_cnt + 32'd1;
            end
            if (w_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign o_data_ready = w_ready;
    assign o_head       = r_head_out;
    assign o_meta       = r_meta_out;
    assign o_head_cnt   = r_head_cnt;
    assign o_err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_head_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_head_assembler
//  Description : Self-checking bench for head_assembler with a head scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_head_assembler;
    import head_assembler_pkg::*;

    localparam int DW = 256;
    localparam int HW = 1024;
    localparam int TW = 8;
    localparam int MW = 512;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_enable;
    logic              i_data_valid;
    logic              i_data_sop;
    logic              i_data_eop;
    logic [DW-1:0]     i_data;
    logic              o_data_ready;
    logic [HW+TW-1:0]  o_head;
    logic [MW+TW-1:0]  o_meta;
    logic [31:0]       o_head_cnt;
    logic [15:0]       o_err_cnt;

    head_assembler #(
        .DATA_WIDTH(DW), .HEAD_WIDTH(HW), .TAG_WIDTH(TW), .META_WIDTH(MW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
        .i_data_valid(i_data_valid), .i_data_sop(i_data_sop),
        .i_data_eop(i_data_eop), .i_data(i_data),
        .o_data_ready(o_data_ready), .o_head(o_head), .o_meta(o_meta),
        .o_head_cnt(o_head_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int vec  = 0;
    int miss = 0;

    typedef struct {
        logic [HW+TW-1:0] head;
        logic [MW+TW-1:0] meta;
        int               cyc;
    } exp_t;

    exp_t          q[$];
    logic [6:0]    exp_pid;
    int            exp_hcnt;
    int            exp_err;
    logic [DW-1:0] bt[0:7];

    typedef struct {
        int len;
        bit en_mid;
        int cap;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [1087:0] act, input logic [1087:0] exp);
        int idx;
        idx = 0;
        vec++;
        if (act !== exp) begin
            miss++;
            for (int i = 16; i >= 0; i--) begin
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
                    idx = i;
                    break;
                end
            end
            $display("FAIL %s: chunk %0d got %h expected %h", nm, idx,
                     act[idx*64 +: 64], exp[idx*64 +: 64]);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected head from the first cap beats of bt, uncaptured slices zero.
    task automatic push_emit(input int cap);
        exp_t          e;
        tag_t          t;
        logic [HW-1:0] h;
        h = '0;
        for (int b = 0; b < cap; b++) h[HW-1-b*DW -: DW] = bt[b];
        t.valid  = 1'b1;
        t.pkt_id = exp_pid;
        e.head   = {h, t};
        e.meta   = {{MW{1'b0}}, t};
        e.cyc    = cyc + 1;
        q.push_back(e);
        exp_pid  = exp_pid + 7'd1;
        exp_hcnt = exp_hcnt + 1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic sop, input logic eop);
        i_data       = d;
        i_data_sop   = sop;
        i_data_eop   = eop;
        i_data_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_data_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst        = 1'b1;
        i_data_valid = 1'b0;
        #1;
        chk("rst_head",  64'(|o_head), 64'd0);
        chk("rst_meta",  64'(|o_meta), 64'd0);
        chk("rst_hcnt",  64'(o_head_cnt), 64'd0);
        chk("rst_err",   64'(o_err_cnt), 64'd0);
        chk("rst_ready", 64'(o_data_ready), 64'd0);
        q.delete();
        exp_pid  = '0;
        exp_hcnt = 0;
        exp_err  = 0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle_cycle();
    endtask

    // Scoreboard monitor: any non-zero head must match the queue head on its cycle.
    always @(posedge i_clk) begin
        exp_t e;
        #2;
        if (o_head != '0) begin
            if (q.size() == 0) begin
                vec++;
                miss++;
                $display("FAIL unexpected_head: got tag %0h expected no head", o_head[TW-1:0]);
            end else begin
                e = q.pop_front();
                chk("head_cycle", 64'(cyc), 64'(e.cyc));
                chk_wide("head", 1088'(o_head), 1088'(e.head));
                chk_wide("meta", 1088'(o_meta), 1088'(e.meta));
            end
        end else begin
            if (o_meta != '0) begin
                vec++;
                miss++;
                $display("FAIL meta_without_head: got tag %0h expected 0", o_meta[TW-1:0]);
            end
            if (q.size() != 0 && q[0].cyc < cyc) begin
                vec++;
                miss++;
                $display("FAIL missing_head: got none expected at cycle %0d", q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    vec_t tbl[8];

    initial begin
        tbl[0] = '{len: 1, en_mid: 1'b1, cap: 1};
        tbl[1] = '{len: 2, en_mid: 1'b0, cap: 2};
        tbl[2] = '{len: 3, en_mid: 1'b0, cap: 3};
        tbl[3] = '{len: 4, en_mid: 1'b1, cap: 4};
        tbl[4] = '{len: 5, en_mid: 1'b0, cap: 4};
        tbl[5] = '{len: 6, en_mid: 1'b1, cap: 4};
        tbl[6] = '{len: 8, en_mid: 1'b0, cap: 4};
        tbl[7] = '{len: 1, en_mid: 1'b0, cap: 1};

        i_enable   = 1'b0;
        i_data_sop = 1'b0;
        i_data_eop = 1'b0;
        i_data     = '0;
        do_reset();

        // Disabled in IDLE: not ready; enabling makes it ready.
        idle_cycle();
        chk("ready_disabled", 64'(o_data_ready), 64'd0);
        i_enable = 1'b1;
        #1;
        chk("ready_enabled", 64'(o_data_ready), 64'd1);

        // Basic 4-beat packet.
        for (int b = 0; b < 4; b++) bt[b] = rnd();
        for (int b = 0; b < 4; b++) begin
            if (b == 3) push_emit(4);
            send_beat(bt[b], b == 0, b == 3);
        end
        chk("basic_tag", 64'(o_head[TW-1:0]), 64'h80);
        chk("basic_meta_tag", 64'(o_meta[TW-1:0]), 64'h80);
        chk("basic_hcnt", 64'(o_head_cnt), 64'd1);
        idle_cycle();

        // Table of packet lengths, with enable dropped mid-packet on some.
        for (int v = 0; v < 8; v++) begin
            i_enable = 1'b1;
            for (int b = 0; b < tbl[v].len; b++) bt[b] = rnd();
            for (int b = 0; b < tbl[v].len; b++) begin
                if (b == tbl[v].cap - 1) push_emit(tbl[v].cap);
                send_beat(bt[b], b == 0, b == tbl[v].len - 1);
                if (b == 0) begin
                    i_enable = tbl[v].en_mid;
                    #1;
                    if (tbl[v].len > 1) chk("ready_mid", 64'(o_data_ready), 64'd1);
                end
            end
            #1;
            chk("ready_end_idle", 64'(o_data_ready), 64'(tbl[v].en_mid));
            idle_cycle();
            chk("tbl_hcnt", 64'(o_head_cnt), 64'(exp_hcnt));
            chk("tbl_err", 64'(o_err_cnt), 64'(exp_err));
        end

        // Non-sop beat in IDLE is discarded and counted.
        i_enable = 1'b1;
        send_beat(rnd(), 1'b0, 1'b1);
        exp_err = exp_err + 1;
        idle_cycle();
        chk("nosop_err", 64'(o_err_cnt), 64'(exp_err));

        // Asynchronous reset in the middle of COLLECT.
        send_beat(rnd(), 1'b1, 1'b0);
        send_beat(rnd(), 1'b0, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_head", 64'(|o_head), 64'd0);
        chk("arst_meta", 64'(|o_meta), 64'd0);
        chk("arst_hcnt", 64'(o_head_cnt), 64'd0);
        chk("arst_err", 64'(o_err_cnt), 64'd0);
        chk("arst_ready", 64'(o_data_ready), 64'd0);
        q.delete();
        exp_pid  = '0;
        exp_hcnt = 0;
        exp_err  = 0;
        i_enable = 1'b0;
        #3;
        i_rst = 1'b0;
        repeat (3) idle_cycle();
        chk("arst_ready_off", 64'(o_data_ready), 64'd0);
        i_enable = 1'b1;
        #1;
        chk("arst_ready_on", 64'(o_data_ready), 64'd1);
        send_beat(rnd(), 1'b0, 1'b0);
        send_beat(rnd(), 1'b0, 1'b1);
        idle_cycle();
        chk("lost_pkt_err", 64'(o_err_cnt), 64'd2);
        chk("lost_pkt_hcnt", 64'(o_head_cnt), 64'd0);

        // sop arriving at beat 3 abandons the open packet.
        do_reset();
        i_enable = 1'b1;
        send_beat(rnd(), 1'b1, 1'b0);
        send_beat(rnd(), 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) bt[b] = rnd();
        for (int b = 0; b < 4; b++) begin
            if (b == 3) push_emit(4);
            send_beat(bt[b], b == 0, b == 3);
        end
        chk("resop_tag", 64'(o_head[TW-1:0]), 64'h80);
        idle_cycle();
        chk("resop_err", 64'(o_err_cnt), 64'd1);
        chk("resop_hcnt", 64'(o_head_cnt), 64'd1);

        // 129 back-to-back single-beat packets: pkt_id wraps 127 -> 0.
        do_reset();
        i_enable = 1'b1;
        for (int i = 0; i < 129; i++) begin
            bt[0] = rnd();
            push_emit(1);
            send_beat(bt[0], 1'b1, 1'b1);
            i_data_valid = 1'b1;
            if (i == 127) chk("b2b_tag127", 64'(o_head[TW-1:0]), 64'hFF);
            if (i == 128) chk("b2b_tag_wrap", 64'(o_head[TW-1:0]), 64'h80);
        end
        i_data_valid = 1'b0;
        idle_cycle();
        chk("b2b_hcnt", 64'(o_head_cnt), 64'd129);

        repeat (3) idle_cycle();
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
`default_nettype wire
